// File: rtl/bfly4_if.sv
// Handshake bundle between the sample buffer, the radix-4 add/sub scheduler and the twiddle stage.
// Data packs four complex samples as {x3.im,x3.re,x2.im,x2.re,x1.im,x1.re,x0.im,x0.re}, x0.re at LSBs.
interface bfly4_if #(
   parameter int W = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [8*W-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [8*W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/bfly4_add_sched.sv
// Radix-4 butterfly (no twiddles) built from one shared halving adder and one halving subtractor.
// Eight add/sub steps per packet: four for the x0/x2 and x1/x3 pairs, four to combine them.
module bfly4_add_sched #(
   parameter int W = 32
) (
   input  logic   clk,
   input  logic   rst,
   bfly4_if.slave bus,
   output logic   busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [1:0]          k_q;
   logic [1:0]          k_d;

   logic signed [W-1:0] x_q [8];
   logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
   logic signed [W-1:0] cr_q, ci_q, dr_q, di_q;
   logic signed [W-1:0] y_q [8];
   logic [8*W-1:0]      out_q;
   logic [8*W-1:0]      res_d;

   logic signed [W-1:0] op_p;
   logic signed [W-1:0] op_q;
   logic signed [W-1:0] sum;
   logic signed [W-1:0] dif;
   logic                in_ready_c;
   logic                out_valid_c;

   // Exact (W+1)-bit sum/difference, then arithmetic shift: floor((p op q)/2) always fits W.
   function automatic logic signed [W-1:0] half_add(input logic signed [W-1:0] p,
                                                    input logic signed [W-1:0] q);
      logic signed [W:0] s;
      s = {p[W-1], p} + {q[W-1], q};
      return s[W:1];
   endfunction

   function automatic logic signed [W-1:0] half_sub(input logic signed [W-1:0] p,
                                                    input logic signed [W-1:0] q);
      logic signed [W:0] s;
      s = {p[W-1], p} - {q[W-1], q};
      return s[W:1];
   endfunction

   assign sum = half_add(op_p, op_q);
   assign dif = half_sub(op_p, op_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      op_p        = '0;
      op_q        = '0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               state_d = S1;
               k_d     = 2'd0;
            end
         end
         S1: begin
            // Step k pairs component k of x0/x1 with the same component of x2/x3.
            op_p = x_q[{1'b0, k_q}];
            op_q = x_q[{1'b1, k_q}];
            k_d  = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = S2;
            end
         end
         S2: begin
            case (k_q)
               2'd0: begin op_p = ar_q; op_q = cr_q; end
               2'd1: begin op_p = ai_q; op_q = ci_q; end
               2'd2: begin op_p = br_q; op_q = di_q; end
               2'd3: begin op_p = bi_q; op_q = dr_q; end
            endcase
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Last S2 step lands X3.im/X1.im straight into the output word so out_data switches only on DONE entry.
   always_comb begin
      res_d = '0;
      for (int i = 0; i < 8; i++) begin
         res_d[i*W +: W] = y_q[i];
      end
      res_d[7*W +: W] = sum;
      res_d[3*W +: W] = dif;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
         ar_q  <= '0;
         ai_q  <= '0;
         br_q  <= '0;
         bi_q  <= '0;
         cr_q  <= '0;
         ci_q  <= '0;
         dr_q  <= '0;
         di_q  <= '0;
         out_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < 8; i++) begin
                     x_q[i] <= bus.in_data[i*W +: W];
                  end
               end
            end
            S1: begin
               case (k_q)
                  2'd0: begin ar_q <= sum; br_q <= dif; end
                  2'd1: begin ai_q <= sum; bi_q <= dif; end
                  2'd2: begin cr_q <= sum; dr_q <= dif; end
                  2'd3: begin ci_q <= sum; di_q <= dif; end
               endcase
            end
            S2: begin
               case (k_q)
                  2'd0: begin y_q[0] <= sum; y_q[4] <= dif; end
                  2'd1: begin y_q[1] <= sum; y_q[5] <= dif; end
                  2'd2: begin y_q[2] <= sum; y_q[6] <= dif; end
                  2'd3: begin
                     y_q[7] <= sum;
                     y_q[3] <= dif;
                     out_q  <= res_d;
                  end
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bfly4_add_sched.sv
// Bench for bfly4_add_sched: fixed vectors, randomized packets against a complex-arithmetic
// butterfly model, and handshake/reset sequences.
module tb_bfly4_add_sched;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   bfly4_if #(.W(W)) bif();

   bfly4_add_sched #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bif.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string          name;
      logic [8*W-1:0] din;
      logic [8*W-1:0] exp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk_vec(input string nm, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [8*W-1:0] pack8(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                            input logic [W-1:0] a2, input logic [W-1:0] a3,
                                            input logic [W-1:0] a4, input logic [W-1:0] a5,
                                            input logic [W-1:0] a6, input logic [W-1:0] a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   // floor(s/2) for any sign
   function automatic longint fl2(input longint s);
      if (s < 0 && (s % 2 != 0)) return (s - 1) / 2;
      return s / 2;
   endfunction

   // Radix-4 butterfly on complex numbers with halving at each of the two stages.
   function automatic logic [8*W-1:0] model(input logic [8*W-1:0] d);
      longint xr[4], xi[4], yr[4], yi[4];
      longint ar, ai, br, bi, cr, ci, dr, di;
      logic [8*W-1:0] r;
      for (int i = 0; i < 4; i++) begin
         xr[i] = longint'($signed(d[2*i*W +: W]));
         xi[i] = longint'($signed(d[(2*i+1)*W +: W]));
      end
      ar = fl2(xr[0] + xr[2]);  ai = fl2(xi[0] + xi[2]);
      br = fl2(xr[0] - xr[2]);  bi = fl2(xi[0] - xi[2]);
      cr = fl2(xr[1] + xr[3]);  ci = fl2(xi[1] + xi[3]);
      dr = fl2(xr[1] - xr[3]);  di = fl2(xi[1] - xi[3]);
      yr[0] = fl2(ar + cr);  yi[0] = fl2(ai + ci);
      yr[2] = fl2(ar - cr);  yi[2] = fl2(ai - ci);
      // X1 = b - j*d, X3 = b + j*d
      yr[1] = fl2(br + di);  yi[1] = fl2(bi - dr);
      yr[3] = fl2(br - di);  yi[3] = fl2(bi + dr);
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[2*i*W +: W]     = W'(yr[i]);
         r[(2*i+1)*W +: W] = W'(yi[i]);
      end
      return r;
   endfunction

   function automatic logic [8*W-1:0] rnd_pkt();
      logic [8*W-1:0] r;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            0:       r[i*W +: W] = 32'h7FFF_FFFF;
            1:       r[i*W +: W] = 32'h8000_0000;
            default: r[i*W +: W] = $urandom;
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One packet through the block; garbage goes onto in_data right after the accept edge.
   task automatic send(input logic [8*W-1:0] d, input bit early_rdy,
                       output logic [8*W-1:0] res, output int lat);
      int n;
      int bad;
      bif.in_data  = d;
      bif.in_valid = 1'b1;
      n = 0;
      while (!bif.in_ready && n < 40) begin
         tick();
         n++;
      end
      chk_int("accept_ready", int'(bif.in_ready), 1);
      tick();
      bif.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) bif.in_data[i*W +: W] = $urandom;
      bif.out_ready = early_rdy;
      lat = 0;
      bad = 0;
      while (!bif.out_valid && lat < 40) begin
         if (bif.in_ready || !busy) bad++;
         tick();
         lat++;
      end
      chk_int("compute_ctrl", bad, 0);
      res = bif.out_data;
      bif.out_ready = 1'b1;
      tick();
      bif.out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8*W-1:0] r, d, e, e2;
      logic [8*W-1:0] pk[2];
      logic [8*W-1:0] got[2];
      int lat, n, bad, nacc, nres;
      int tacc[2];

      vecs[0] = '{"basic", pack8(8, 0, 4, 0, 2, 0, 0, 0), pack8(3, 0, 1, -1, 1, 0, 1, 1)};
      vecs[1] = '{"floor", pack8(-1, 0, 0, 0, 0, 0, 0, 0), pack8(-1, 0, -1, 0, -1, 0, -1, 0)};
      vecs[2] = '{"extremes",
                  pack8(32'h7FFF_FFFF, 0, 32'h8000_0000, 0, 32'h7FFF_FFFF, 0, 32'h8000_0000, 0),
                  pack8(-1, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0)};
      vecs[3] = '{"imag_x0", pack8(0, 8, 0, 0, 0, 0, 0, 0), pack8(0, 2, 0, 2, 0, 2, 0, 2)};
      vecs[4] = '{"real_x1", pack8(0, 0, 4, 0, 0, 0, 0, 0), pack8(1, 0, 0, -1, -1, 0, 0, 1)};

      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk_int("rst_in_ready", int'(bif.in_ready), 1);
      chk_int("rst_out_valid", int'(bif.out_valid), 0);
      chk_int("rst_busy", int'(busy), 0);
      chk_vec("rst_out_data", bif.out_data, '0);

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].din, 1'(i % 2), r, lat);
         chk_vec(vecs[i].name, r, vecs[i].exp);
         chk_int("latency", lat, 8);
      end

      for (int i = 0; i < 20; i++) begin
         d = rnd_pkt();
         send(d, 1'($urandom_range(0, 1)), r, lat);
         chk_vec("random", r, model(d));
         chk_int("random_latency", lat, 8);
      end

      // Backpressure: hold DONE for 20 cycles, then a one-cycle out_ready pulse.
      d = rnd_pkt();
      e = model(d);
      bif.in_data  = d;
      bif.in_valid = 1'b1;
      tick();
      bif.in_valid = 1'b0;
      n = 0;
      while (!bif.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk_int("bp_latency", n, 8);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bif.out_valid || bif.out_data !== e || bif.in_ready) bad++;
         tick();
      end
      chk_int("bp_hold", bad, 0);
      chk_vec("bp_data", bif.out_data, e);
      bif.out_ready = 1'b1;
      tick();
      bif.out_ready = 1'b0;
      chk_int("bp_idle_in_ready", int'(bif.in_ready), 1);
      chk_int("bp_idle_out_valid", int'(bif.out_valid), 0);
      chk_int("bp_idle_busy", int'(busy), 0);
      chk_vec("bp_data_held", bif.out_data, e);

      // Back-to-back: in_valid held high with two packets queued, out_ready always high.
      pk[0] = rnd_pkt();
      pk[1] = rnd_pkt();
      got[0] = '0;
      got[1] = '0;
      tacc[0] = -1;
      tacc[1] = -1;
      nacc = 0;
      nres = 0;
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      bif.in_data   = pk[0];
      for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
         automatic bit acc = bif.in_valid && bif.in_ready;
         if (bif.out_valid && nres < 2) begin
            got[nres] = bif.out_data;
            nres++;
         end
         if (acc && nacc < 2) tacc[nacc] = cyc;
         tick();
         if (acc && nacc < 2) begin
            nacc++;
            if (nacc == 1) bif.in_data = pk[1];
            else bif.in_valid = 1'b0;
         end
      end
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      chk_int("b2b_results", nres, 2);
      chk_int("b2b_accept_gap", tacc[1] - tacc[0], 10);
      chk_vec("b2b_first", got[0], model(pk[0]));
      chk_vec("b2b_second", got[1], model(pk[1]));
      tick();

      // Reset in S2 with k=1, then a fresh packet.
      d = rnd_pkt();
      bif.in_data  = d;
      bif.in_valid = 1'b1;
      tick();
      bif.in_valid = 1'b0;
      repeat (5) tick();
      chk_int("pre_reset_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_int("mid_rst_out_valid", int'(bif.out_valid), 0);
      chk_int("mid_rst_busy", int'(busy), 0);
      chk_int("mid_rst_in_ready", int'(bif.in_ready), 1);
      chk_vec("mid_rst_out_data", bif.out_data, '0);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (bif.out_valid) bad++;
         tick();
      end
      chk_int("no_stale_output", bad, 0);
      d = rnd_pkt();
      e2 = model(d);
      send(d, 1'b0, r, lat);
      chk_vec("post_reset_packet", r, e2);
      chk_int("post_reset_latency", lat, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
